// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op encodings, FSM state encoding and default latencies
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with architectural HI/LO
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops)
// Ports:
//   clk       in   pipeline clock, rising edge
//   reset     in   synchronous active-high reset
//   Start     in   E-stage valid strobe for MDUOp
//   MDUOp     in   4-bit op code (mdu_op_e)
//   SrcA/SrcB in   32-bit forwarded rs/rt operands
//   Busy      out  high while a multiply/divide is in flight
//   MDUResult out  HI on mfhi, LO on mflo, else 0 (combinational)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] MDUResult
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] shadow_hi_q, shadow_lo_q;
  logic [31:0] shadow_hi_d, shadow_lo_d;

  logic        is_mul_op, is_div_op, signed_op;
  logic [63:0] a_ext, b_ext, prod, mul_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
`ifdef MDU_MADD_EN
  logic        acc_op, sub_op;
`endif

  // Op decode; accumulate ops only exist when the feature is built in.
  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    signed_op = 1'b0;
`ifdef MDU_MADD_EN
    acc_op    = 1'b0;
    sub_op    = 1'b0;
`endif
    case (MDUOp)
      OP_MULT:  begin is_mul_op = 1'b1; signed_op = 1'b1; end
      OP_MULTU: begin is_mul_op = 1'b1; end
      OP_DIV:   begin is_div_op = 1'b1; signed_op = 1'b1; end
      OP_DIVU:  begin is_div_op = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul_op = 1'b1; signed_op = 1'b1; acc_op = 1'b1; end
      OP_MADDU: begin is_mul_op = 1'b1; acc_op = 1'b1; end
      OP_MSUB:  begin is_mul_op = 1'b1; signed_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; end
      OP_MSUBU: begin is_mul_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  // One 64x64 multiplier serves both signednesses: the low 64 bits of the
  // product of sign- (or zero-) extended operands is the exact result.
  assign a_ext = {{32{signed_op & SrcA[31]}}, SrcA};
  assign b_ext = {{32{signed_op & SrcB[31]}}, SrcB};
  assign prod  = a_ext * b_ext;

`ifdef MDU_MADD_EN
  always_comb begin
    mul_res = prod;
    if (acc_op) mul_res = sub_op ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  end
`else
  assign mul_res = prod;
`endif

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on operator overflow behaviour.
  assign a_neg  = signed_op & SrcA[31];
  assign b_neg  = signed_op & SrcB[31];
  assign a_mag  = a_neg ? (~SrcA + 32'd1) : SrcA;
  assign b_mag  = b_neg ? (~SrcB + 32'd1) : SrcB;
  assign b_safe = (SrcB == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  // HI/LO cannot change while busy, so a divide by zero simply shadows the
  // current HI/LO and the commit rewrites the same values.
  always_comb begin
    shadow_hi_d = mul_res[63:32];
    shadow_lo_d = mul_res[31:0];
    if (is_div_op) begin
      if (SrcB == 32'd0) begin
        shadow_hi_d = hi_q;
        shadow_lo_d = lo_q;
      end else begin
        shadow_hi_d = rem;
        shadow_lo_d = quot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (is_mul_op || is_div_op) begin
              shadow_hi_q <= shadow_hi_d;
              shadow_lo_q <= shadow_lo_d;
              busy_q      <= 1'b1;
              cnt_q       <= is_mul_op ? MULT_N : DIV_N;
              state_q     <= is_mul_op ? ST_MUL : ST_DIV;
            end else if (MDUOp == OP_MTHI) begin
              hi_q <= SrcA;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= SrcA;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == 4'd1) begin
            hi_q    <= shadow_hi_q;
            lo_q    <= shadow_lo_q;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy = busy_q;

  always_comb begin
    MDUResult = 32'd0;
    if (MDUOp == OP_MFHI) MDUResult = hi_q;
    else if (MDUOp == OP_MFLO) MDUResult = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] MDUResult;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .MDUResult(MDUResult)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          lat;
    int          idx;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one op for a single accept edge; returns at the negedge after it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = OP_NONE; SrcA = 32'd0; SrcB = 32'd0;
  endtask

  // Counts busy cycles sampled at negedges; bounded so a stuck Busy ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (Busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: Busy still high after %0d cycles", n);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDUOp = OP_MFHI; #1 hi = MDUResult;
    MDUOp = OP_MFLO; #1 lo = MDUResult;
    MDUOp = OP_NONE; #1;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int n, n_pre;
    exp_t e;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};

    reset = 1'b1; Start = 1'b0; MDUOp = OP_NONE; SrcA = 32'd0; SrcB = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check32("reset_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);

    // Table-driven ops through the scoreboard
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].lat, i});
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      read_hilo(hi, lo);
      e = sb.pop_front();
      check_int($sformatf("vec%0d_busy_cycles", e.idx), n, e.lat);
      check32($sformatf("vec%0d_hi", e.idx), hi, e.hi);
      check32($sformatf("vec%0d_lo", e.idx), lo, e.lo);
    end

    // mflo during a divide returns the old LO
    issue(OP_MTLO, 32'h0000ABCD, 32'd0);
    check32("mtlo_no_busy", {31'd0, Busy}, 32'd0);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (3) @(negedge clk);
    read_hilo(hi, lo);
    check32("div_mid_busy", {31'd0, Busy}, 32'd1);
    check32("div_mid_old_lo", lo, 32'h0000ABCD);
    wait_idle(n);
    check_int("div_mid_busy_cycles", n + 3, 10);
    read_hilo(hi, lo);
    check32("div_mid_hi", hi, 32'hFFFFFFFF);
    check32("div_mid_lo", lo, 32'hFFFFFFFD);

    // Divide by zero, with ops issued while busy ignored
    issue(OP_MTHI, 32'h00001234, 32'd0);
    issue(OP_MTLO, 32'h00000077, 32'd0);
    issue(OP_DIVU, 32'd100, 32'd0);
    @(negedge clk);
    issue(OP_MTLO, 32'h00000055, 32'd0);
    issue(OP_MULT, 32'd3, 32'd3);
    n_pre = 5;
    wait_idle(n);
    check_int("divz_busy_cycles", n + n_pre, 10);
    repeat (2) @(negedge clk);
    check32("divz_no_restart", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check32("divz_hi", hi, 32'h00001234);
    check32("divz_lo", lo, 32'h00000077);

    // Undefined op codes and read ops with Start do nothing
    issue(4'd13, 32'hDEADBEEF, 32'd1);
    issue(OP_MFHI, 32'hDEADBEEF, 32'd1);
    issue(OP_NONE, 32'hDEADBEEF, 32'd1);
    check32("badop_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check32("badop_hi", hi, 32'h00001234);
    check32("badop_lo", lo, 32'h00000077);

    // Reset at cycle 3 of a divide aborts with no later commit
    issue(OP_MTHI, 32'h000000AA, 32'd0);
    issue(OP_MTLO, 32'h000000BB, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("rst_mid_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check32("rst_mid_hi", hi, 32'd0);
    check32("rst_mid_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check32("rst_late_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    check32("rst_late_hi", hi, 32'd0);
    check32("rst_late_lo", lo, 32'd0);

    // Reset wins over a simultaneous Start
    issue(OP_MTLO, 32'h00000099, 32'd0);
    @(negedge clk);
    reset = 1'b1; Start = 1'b1; MDUOp = OP_MTLO; SrcA = 32'h00000005;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDUOp = OP_NONE; SrcA = 32'd0;
    read_hilo(hi, lo);
    check32("rst_vs_start_lo", lo, 32'd0);

    // Accumulate: mtlo 10, mthi 0, madd 3*4
    issue(OP_MTLO, 32'd10, 32'd0);
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MADD, 32'd3, 32'd4);
    wait_idle(n);
    read_hilo(hi, lo);
`ifdef MDU_MADD_EN
    check_int("madd_busy_cycles", n, 5);
    check32("madd_lo", lo, 32'd22);
    check32("madd_hi", hi, 32'd0);
    issue(OP_MSUB, 32'd5, 32'd5);
    wait_idle(n);
    read_hilo(hi, lo);
    check_int("msub_busy_cycles", n, 5);
    check32("msub_lo", lo, 32'hFFFFFFFD);
    check32("msub_hi", hi, 32'hFFFFFFFF);
`else
    check_int("madd_busy_cycles", n, 0);
    check32("madd_lo", lo, 32'd10);
    check32("madd_hi", hi, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
